// File: rtl/decoder8_pkg.sv
// Shared constants, state encoding and the one-hot helper for decoder8_strobe.
package decoder8_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_HOLD = ST_HOLD,
        S_GAP  = ST_GAP
    } state_e;

    function automatic logic [7:0] onehot8(input logic [2:0] code);
        return 8'b1 << code;
    endfunction

endpackage

// File: rtl/dec3to8_comb.sv
// Pure combinational 3->8 one-hot decoder; forms the next strobe value.
module dec3to8_comb
    import decoder8_pkg::*;
(
    input  logic [2:0] code_i,
    output logic [7:0] onehot_o
);

    assign onehot_o = onehot8(code_i);

endmodule

// File: rtl/decoder8_strobe.sv
// Sequential 3-to-8 decoder: accepts a binary code over valid/ready and
// drives the matching one-hot strobe for HOLD_CYCLES, then an all-zero gap
// of GAP_CYCLES before the next code is accepted.
// Optional build macro DECODER8_STROBE_SCAN_EN adds a scan_en input that
// self-launches strobes from a wrapping 3-bit pointer while idle.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a code, code_ready high, data all zero
// HOLD  | one-hot strobe on data, counting down the hold time
// GAP   | data all zero, counting down the idle gap
module decoder8_strobe
    import decoder8_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef DECODER8_STROBE_SCAN_EN
    input  logic       scan_en,
`endif
    input  logic       code_valid,
    input  logic [2:0] code,
    output logic       code_ready,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    // Truncated to 8 bits; only used when GAP_CYCLES is non-zero.
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;

    logic             idle;
    logic             ext_accept;
    logic             launch;
    logic [2:0]       sel_code;
    logic [7:0]       next_onehot;

    assign idle       = (state_q == S_IDLE);
    assign ext_accept = code_valid && idle;

`ifdef DECODER8_STROBE_SCAN_EN
    logic [2:0] scan_ptr_q, scan_ptr_d;
    logic       scan_launch;

    // An external code always wins; the pointer only moves on a scan launch.
    assign scan_launch = idle && scan_en && !code_valid;
    assign launch      = ext_accept || scan_launch;
    assign sel_code    = ext_accept ? code : scan_ptr_q;
    assign scan_ptr_d  = scan_launch ? scan_ptr_q + 3'd1 : scan_ptr_q;

    // Scan pointer register, wraps 7 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_ptr_q <= 3'd0;
        end else begin
            scan_ptr_q <= scan_ptr_d;
        end
    end
`else
    assign launch   = ext_accept;
    assign sel_code = code;
`endif

    dec3to8_comb u_dec (
        .code_i   (sel_code),
        .onehot_o (next_onehot)
    );

    // Next-state, counter and strobe computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dv_d    = dv_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    data_d  = next_onehot;
                    dv_d    = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    data_d = 8'h00;
                    dv_d   = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                data_d  = 8'h00;
                dv_d    = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any strobe at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
        end
    end

    assign code_ready = idle;
    assign busy       = !idle;
    assign data       = data_q;
    assign data_valid = dv_q;

endmodule

// File: tb/tb_decoder8_strobe.sv
// Scoreboard bench for decoder8_strobe: instance A (HOLD=4, GAP=1) and
// instance B (HOLD=1, GAP=0). Stimulus pushes expected codes; monitors pop
// them whenever data_valid is seen and also loop data through an 8x3 encoder.
module tb_decoder8_strobe;

    localparam int HA = 4;
    localparam int GA = 1;
    localparam int HB = 1;
    localparam int GB = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid_a, code_valid_b;
    logic [2:0] code_a, code_b;
    logic       ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b;
    logic       busy_a, busy_b;
`ifdef DECODER8_STROBE_SCAN_EN
    logic       scan_en_a, scan_en_b;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int qa[$];
    int qb[$];
    int ca, cb;

    always #5 clk = ~clk;

    decoder8_strobe #(.HOLD_CYCLES(HA), .GAP_CYCLES(GA)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DECODER8_STROBE_SCAN_EN
        .scan_en    (scan_en_a),
`endif
        .code_valid (code_valid_a),
        .code       (code_a),
        .code_ready (ready_a),
        .data       (data_a),
        .data_valid (dv_a),
        .busy       (busy_a)
    );

    decoder8_strobe #(.HOLD_CYCLES(HB), .GAP_CYCLES(GB)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DECODER8_STROBE_SCAN_EN
        .scan_en    (scan_en_b),
`endif
        .code_valid (code_valid_b),
        .code       (code_b),
        .code_ready (ready_b),
        .data       (data_b),
        .data_valid (dv_b),
        .busy       (busy_b)
    );

    function automatic logic [7:0] exp_oh(input int c);
        logic [7:0] one;
        one = 8'd1;
        return one << c;
    endfunction

    function automatic logic [2:0] enc8x3(input logic [7:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (d[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int c);
        code_valid_a = 1'b1;
        code_a       = 3'(c);
        for (int i = 0; i < HA; i++) qa.push_back(c);
        tick();
        code_valid_a = 1'b0;
    endtask

    // Monitors: compare every presented strobe against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_dv_vs_data", 32'(dv_a), 32'(data_a != 8'h00));
            if (dv_a) begin
                if (qa.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL a_extra_strobe: got data %02h expected none", data_a);
                end else begin
                    ca = qa.pop_front();
                    chk("a_data", 32'(data_a), 32'(exp_oh(ca)));
                    chk("a_loopback", 32'(enc8x3(data_a)), 32'(ca));
                end
            end
            chk("b_dv_vs_data", 32'(dv_b), 32'(data_b != 8'h00));
            if (dv_b) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL b_extra_strobe: got data %02h expected none", data_b);
                end else begin
                    cb = qb.pop_front();
                    chk("b_data", 32'(data_b), 32'(exp_oh(cb)));
                    chk("b_loopback", 32'(enc8x3(data_b)), 32'(cb));
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        code_valid_a = 1'b0;
        code_valid_b = 1'b0;
        code_a       = 3'd0;
        code_b       = 3'd0;
`ifdef DECODER8_STROBE_SCAN_EN
        scan_en_a    = 1'b0;
        scan_en_b    = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        chk("rst_a_data",  32'(data_a),  32'h00);
        chk("rst_a_dv",    32'(dv_a),    32'd0);
        chk("rst_a_ready", 32'(ready_a), 32'd1);
        chk("rst_a_busy",  32'(busy_a),  32'd0);
        chk("rst_b_data",  32'(data_b),  32'h00);
        chk("rst_b_ready", 32'(ready_b), 32'd1);
        rst_n = 1'b1;

        // Code 5 on A: strobe for HA cycles, GA gap cycles, then ready again
        send_a(5);
        code_a = 3'd7;
        chk("t5_ready_low", 32'(ready_a), 32'd0);
        chk("t5_busy",      32'(busy_a),  32'd1);
        chk("t5_data",      32'(data_a),  32'h20);
        repeat (HA - 1) tick();
        chk("t5_last_hold", 32'(data_a),  32'h20);
        tick();
        chk("t5_gap_data",  32'(data_a),  32'h00);
        chk("t5_gap_ready", 32'(ready_a), 32'd0);
        chk("t5_gap_busy",  32'(busy_a),  32'd1);
        tick();
        chk("t5_ready_back", 32'(ready_a), 32'd1);
        chk("t5_idle_busy",  32'(busy_a),  32'd0);

        // Code changes and valid pulses during HOLD are ignored
        send_a(2);
        code_valid_a = 1'b1;
        code_a       = 3'd6;
        tick();
        tick();
        code_valid_a = 1'b0;
        chk("ign_data_held", 32'(data_a), 32'h04);
        repeat (HA + GA - 2) tick();
        chk("ign_ready", 32'(ready_a), 32'd1);
        repeat (HA + GA + 2) tick();
        chk("ign_no_extra", 32'(busy_a), 32'd0);

        // Loopback through the encoder for all codes
        for (int c = 0; c < 8; c++) begin
            send_a(c);
            repeat (HA + GA) tick();
        end
        chk("loop_drained", 32'(qa.size()), 32'd0);

        // Reset mid-HOLD aborts the strobe
        send_a(3);
        tick();
        rst_n = 1'b0;
        tick();
        qa.delete();
        chk("mid_rst_data",  32'(data_a),  32'h00);
        chk("mid_rst_dv",    32'(dv_a),    32'd0);
        chk("mid_rst_ready", 32'(ready_a), 32'd1);
        chk("mid_rst_busy",  32'(busy_a),  32'd0);
        rst_n = 1'b1;
        tick();

        // B: HOLD=1, GAP=0, valid held high, accept every other cycle
        code_valid_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            code_b = 3'(i);
            qb.push_back(i);
            tick();
            chk("b2b_strobe", 32'(data_b), 32'(exp_oh(i)));
            tick();
            chk("b2b_zero",  32'(data_b),  32'h00);
            chk("b2b_ready", 32'(ready_b), 32'd1);
        end
        code_valid_b = 1'b0;
        repeat (3) tick();
        chk("b2b_idle", 32'(busy_b), 32'd0);

`ifdef DECODER8_STROBE_SCAN_EN
        // Scan: 0..7 then wrap to 0; external code 2 wins without advancing
        scan_en_b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            qb.push_back(i % 8);
            tick();
            chk("scan_strobe", 32'(data_b), 32'(exp_oh(i % 8)));
            tick();
        end
        code_valid_b = 1'b1;
        code_b       = 3'd2;
        qb.push_back(2);
        tick();
        code_valid_b = 1'b0;
        chk("scan_ext_wins", 32'(data_b), 32'h04);
        tick();
        qb.push_back(1);
        tick();
        chk("scan_resume", 32'(data_b), 32'h02);
        tick();
        qb.push_back(2);
        tick();
        chk("scan_next", 32'(data_b), 32'h04);
        scan_en_b = 1'b0;
        repeat (3) tick();
        chk("scan_stop", 32'(busy_b), 32'd0);
`endif

        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
